// File: rtl/clock_pkg.sv
// Shared types and constants for the alarm ring controller.
package clock_pkg;

  localparam int SEC_W        = 9;
  localparam int HOLDOFF_SEC  = 60;
  localparam int ESCALATE_SEC = 30;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_RINGING  = 3'd1,
    ST_CLEARING = 3'd2,
    ST_SNOOZE   = 3'd3,
    ST_HOLDOFF  = 3'd4
  } ring_state_e;

  // Last tick value of an n-second interval (counter runs 0..n-1).
  function automatic logic [SEC_W-1:0] last_tick(input int n);
    return SEC_W'(n - 1);
  endfunction

endpackage

// File: rtl/sec_tick_counter.sv
// 9-bit seconds counter: synchronous clear, count enable, terminal compare.
// Exposes the next-cycle count so callers can register outputs derived from it.
module sec_tick_counter
  import clock_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic [SEC_W-1:0] term_val,
  output logic [SEC_W-1:0] cnt_nxt,
  output logic             at_term
);

  logic [SEC_W-1:0] cnt_q, cnt_d;

  // Next count: clear beats enable; no wrap handling, callers clear at terminal.
  always_comb begin
    cnt_d = cnt_q;
    if (clr)     cnt_d = '0;
    else if (en) cnt_d = cnt_q + 1'b1;
  end

  // Count register.
  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign cnt_nxt = cnt_d;
  assign at_term = (cnt_q == term_val);

endmodule

// File: rtl/alarm_ring_ctrl.sv
// Alarm ring controller: ring / snooze / dismiss sequencing with a
// post-dismiss holdoff that suppresses same-minute retriggering.
// Optional feature macro: ALARM_RING_ESCALATE_EN (buzzer goes steady after
// ESCALATE_SEC seconds of ringing).
module alarm_ring_ctrl
  import clock_pkg::*;
#(
  parameter int SNOOZE_SEC       = 300,
  parameter int RING_TIMEOUT_SEC = 60,
  parameter int MAX_SNOOZE       = 3
) (
  input  logic       sys_clk,
  input  logic       rst,
  input  logic       clk_1hz_en,
  input  logic       alarm_enable_in,
  input  logic       alarm_trigger_in,
  input  logic       snooze_btn,
  input  logic       off_btn,
  output logic       alarm_clear_out,
  output logic       buzzer_out,
  output logic       snooze_active_out,
  output logic [1:0] snooze_count_out
);

  localparam logic [SEC_W-1:0] RING_LAST    = last_tick(RING_TIMEOUT_SEC);
  localparam logic [SEC_W-1:0] SNOOZE_LAST  = last_tick(SNOOZE_SEC);
  localparam logic [SEC_W-1:0] HOLDOFF_LAST = last_tick(HOLDOFF_SEC);
  localparam logic [1:0]       MAX_SNZ      = 2'(MAX_SNOOZE);
`ifdef ALARM_RING_ESCALATE_EN
  localparam logic [SEC_W-1:0] ESC_AT       = SEC_W'(ESCALATE_SEC);
`endif

  ring_state_e      state_q, state_d;
  logic [1:0]       snooze_cnt_q, snooze_cnt_d;
  logic             snz_flag_q, snz_flag_d;   // CLEARING exits to SNOOZE when set
  logic             trig_prev_q, trig_prev_d;
  logic             buzzer_q, buzzer_d;
  logic             clear_q, clear_d;

  logic             cnt_clr, cnt_en, at_term;
  logic [SEC_W-1:0] term_val, sec_cnt_d;

  logic trig_edge, can_snooze, ring_timeout, do_off, do_snooze;

  sec_tick_counter u_sec_cnt (
    .clk      (sys_clk),
    .rst      (rst),
    .clr      (cnt_clr),
    .en       (cnt_en),
    .term_val (term_val),
    .cnt_nxt  (sec_cnt_d),
    .at_term  (at_term)
  );

  // Terminal count depends on which interval the current state is timing.
  always_comb begin
    term_val = HOLDOFF_LAST;
    case (state_q)
      ST_RINGING: term_val = RING_LAST;
      ST_SNOOZE:  term_val = SNOOZE_LAST;
      default:    term_val = HOLDOFF_LAST;
    endcase
  end

  assign trig_edge    = alarm_trigger_in & ~trig_prev_q;
  assign can_snooze   = (snooze_cnt_q < MAX_SNZ);
  assign ring_timeout = clk_1hz_en & at_term;
  // Off beats snooze; an unattended timeout acts as whichever button applies.
  assign do_off       = off_btn | (ring_timeout & ~can_snooze);
  assign do_snooze    = ~off_btn & can_snooze & (snooze_btn | ring_timeout);

  // Next-state logic; alarm_enable_in low overrides everything.
  always_comb begin
    state_d      = state_q;
    snooze_cnt_d = snooze_cnt_q;
    snz_flag_d   = snz_flag_q;
    trig_prev_d  = alarm_trigger_in;
    cnt_clr      = 1'b0;
    cnt_en       = 1'b0;
    if (!alarm_enable_in) begin
      state_d      = ST_IDLE;
      snooze_cnt_d = '0;
      snz_flag_d   = 1'b0;
      cnt_clr      = 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (trig_edge) begin
            state_d      = ST_RINGING;
            snooze_cnt_d = '0;
            cnt_clr      = 1'b1;
          end
        end
        ST_RINGING: begin
          if (do_off) begin
            state_d    = ST_CLEARING;
            snz_flag_d = 1'b0;
            cnt_clr    = 1'b1;
          end else if (do_snooze) begin
            state_d      = ST_CLEARING;
            snz_flag_d   = 1'b1;
            snooze_cnt_d = snooze_cnt_q + 1'b1;
            cnt_clr      = 1'b1;
          end else if (clk_1hz_en) begin
            cnt_en = 1'b1;
          end
        end
        ST_CLEARING: begin
          // Comparator only samples its off input on a 1 Hz tick.
          if (clk_1hz_en) begin
            state_d = snz_flag_q ? ST_SNOOZE : ST_HOLDOFF;
            cnt_clr = 1'b1;
          end
        end
        ST_SNOOZE: begin
          if (off_btn) begin
            state_d = ST_HOLDOFF;
            cnt_clr = 1'b1;
          end else if (clk_1hz_en) begin
            if (at_term) begin
              state_d = ST_RINGING;
              cnt_clr = 1'b1;
            end else begin
              cnt_en = 1'b1;
            end
          end
        end
        ST_HOLDOFF: begin
          if (clk_1hz_en) begin
            if (at_term) begin
              state_d = ST_IDLE;
              cnt_clr = 1'b1;
            end else begin
              cnt_en = 1'b1;
            end
          end
        end
        default: begin
          state_d = ST_IDLE;
          cnt_clr = 1'b1;
        end
      endcase
    end
  end

  // Registered outputs computed from next state so they line up with it.
  always_comb begin
    buzzer_d = 1'b0;
    clear_d  = (state_d == ST_CLEARING);
    if (state_d == ST_RINGING) begin
      buzzer_d = ~sec_cnt_d[0];
`ifdef ALARM_RING_ESCALATE_EN
      if (sec_cnt_d >= ESC_AT) buzzer_d = 1'b1;
`endif
    end
  end

  // State and output registers.
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      snooze_cnt_q <= '0;
      snz_flag_q   <= 1'b0;
      trig_prev_q  <= 1'b0;
      buzzer_q     <= 1'b0;
      clear_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      snooze_cnt_q <= snooze_cnt_d;
      snz_flag_q   <= snz_flag_d;
      trig_prev_q  <= trig_prev_d;
      buzzer_q     <= buzzer_d;
      clear_q      <= clear_d;
    end
  end

  assign alarm_clear_out   = clear_q;
  assign buzzer_out        = buzzer_q;
  assign snooze_active_out = (state_q == ST_SNOOZE);
  assign snooze_count_out  = snooze_cnt_q;

endmodule

// File: tb/tb_alarm_ring_ctrl.sv
// Directed bench for alarm_ring_ctrl; expected output vectors are queued
// when each step is driven and checked after the clock edge.
module tb_alarm_ring_ctrl;

`ifdef ALARM_RING_ESCALATE_EN
  localparam int RT = 40;
`else
  localparam int RT = 4;
`endif

  logic       sys_clk = 1'b0;
  logic       rst, clk_1hz_en, alarm_enable_in, alarm_trigger_in, snooze_btn, off_btn;
  logic       alarm_clear_out, buzzer_out, snooze_active_out;
  logic [1:0] snooze_count_out;

  typedef struct { string tag; logic [4:0] want; } exp_t;
  exp_t sb_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 sys_clk = ~sys_clk;

  alarm_ring_ctrl #(.SNOOZE_SEC(5), .RING_TIMEOUT_SEC(RT), .MAX_SNOOZE(2)) dut (
    .sys_clk           (sys_clk),
    .rst               (rst),
    .clk_1hz_en        (clk_1hz_en),
    .alarm_enable_in   (alarm_enable_in),
    .alarm_trigger_in  (alarm_trigger_in),
    .snooze_btn        (snooze_btn),
    .off_btn           (off_btn),
    .alarm_clear_out   (alarm_clear_out),
    .buzzer_out        (buzzer_out),
    .snooze_active_out (snooze_active_out),
    .snooze_count_out  (snooze_count_out)
  );

  // Packs {clear, buzzer, snooze_active, snooze_count}.
  function automatic logic [4:0] ex(input logic c, input logic b, input logic s,
                                    input logic [1:0] n);
    return {c, b, s, n};
  endfunction

  // One clock with current inputs; pulses drop afterwards.
  task automatic cyc(input string tag, input logic [4:0] e);
    exp_t       it;
    logic [4:0] obs;
    sb_q.push_back('{tag: tag, want: e});
    @(posedge sys_clk);
    #1;
    snooze_btn = 1'b0;
    off_btn    = 1'b0;
    clk_1hz_en = 1'b0;
    obs = {alarm_clear_out, buzzer_out, snooze_active_out, snooze_count_out};
    it  = sb_q.pop_front();
    n_tests++;
    assert (obs === it.want) else begin
      n_fail++;
      $error("FAIL %s observed=%b expected=%b", it.tag, obs, it.want);
    end
  endtask

  task automatic ticks(input string tag, input int n, input logic [4:0] e);
    for (int k = 0; k < n; k++) begin
      clk_1hz_en = 1'b1;
      cyc(tag, e);
    end
  endtask

  task automatic tick(input string tag, input logic [4:0] e);
    clk_1hz_en = 1'b1;
    cyc(tag, e);
  endtask

  initial begin
    rst = 1'b1; alarm_enable_in = 1'b1; alarm_trigger_in = 1'b1;
    clk_1hz_en = 1'b0; snooze_btn = 1'b0; off_btn = 1'b0;
    cyc("reset", ex(0,0,0,2'd0));
    rst = 1'b0;
    // Trigger already high: edge register was cleared by reset.
    cyc("trig_after_rst", ex(0,1,0,2'd0));
`ifdef ALARM_RING_ESCALATE_EN
    for (int i = 1; i < 30; i++) tick("esc_pulse", ex(0, ~i[0], 0, 2'd0));
    for (int i = 30; i < 40; i++) tick("esc_steady", ex(0,1,0,2'd0));
    tick("esc_timeout", ex(1,0,0,2'd1));
`else
    cyc("ring_no_tick", ex(0,1,0,2'd0));
    tick("ring_t1", ex(0,0,0,2'd0));
    tick("ring_t2", ex(0,1,0,2'd0));
    snooze_btn = 1'b1;
    cyc("snooze_press", ex(1,0,0,2'd1));
    cyc("clear_hold", ex(1,0,0,2'd1));
    tick("clear_to_snooze", ex(0,0,1,2'd1));
    snooze_btn = 1'b1;
    cyc("snooze_btn_ignored", ex(0,0,1,2'd1));
    ticks("snoozing", 4, ex(0,0,1,2'd1));
    tick("snooze_done", ex(0,1,0,2'd1));
    // Unattended ringing: first timeout snoozes.
    tick("ring2_t1", ex(0,0,0,2'd1));
    tick("ring2_t2", ex(0,1,0,2'd1));
    tick("ring2_t3", ex(0,0,0,2'd1));
    tick("timeout_snooze", ex(1,0,0,2'd2));
    cyc("clear2_hold", ex(1,0,0,2'd2));
    tick("clear2_exit", ex(0,0,1,2'd2));
    ticks("snoozing2", 4, ex(0,0,1,2'd2));
    tick("snooze2_done", ex(0,1,0,2'd2));
    snooze_btn = 1'b1;
    cyc("snooze_at_max", ex(0,1,0,2'd2));
    tick("ring3_t1", ex(0,0,0,2'd2));
    tick("ring3_t2", ex(0,1,0,2'd2));
    tick("ring3_t3", ex(0,0,0,2'd2));
    tick("timeout_dismiss", ex(1,0,0,2'd2));
    tick("to_holdoff", ex(0,0,0,2'd2));
    ticks("holdoff", 59, ex(0,0,0,2'd2));
    alarm_trigger_in = 1'b0;
    cyc("holdoff_trig_low", ex(0,0,0,2'd2));
    alarm_trigger_in = 1'b1;
    cyc("holdoff_edge_ignored", ex(0,0,0,2'd2));
    tick("holdoff_exit", ex(0,0,0,2'd2));
    cyc("idle_level_ignored", ex(0,0,0,2'd2));
    alarm_trigger_in = 1'b0;
    cyc("idle_trig_low", ex(0,0,0,2'd2));
    alarm_trigger_in = 1'b1;
    cyc("idle_edge", ex(0,1,0,2'd0));
    // Off and snooze together: off wins.
    off_btn = 1'b1; snooze_btn = 1'b1;
    cyc("off_wins", ex(1,0,0,2'd0));
    tick("dismiss_holdoff", ex(0,0,0,2'd0));
    alarm_enable_in = 1'b0;
    cyc("disable_holdoff", ex(0,0,0,2'd0));
    alarm_enable_in = 1'b1;
    alarm_trigger_in = 1'b0;
    cyc("rearm_low", ex(0,0,0,2'd0));
    alarm_trigger_in = 1'b1;
    cyc("ring_after_disable", ex(0,1,0,2'd0));
    snooze_btn = 1'b1;
    cyc("snooze_press3", ex(1,0,0,2'd1));
    tick("snooze3", ex(0,0,1,2'd1));
    off_btn = 1'b1;
    cyc("snooze_off", ex(0,0,0,2'd1));
    alarm_enable_in = 1'b0;
    cyc("disable_clears_cnt", ex(0,0,0,2'd0));
    alarm_enable_in = 1'b1;
    // Enable dropped mid-snooze, together with a tick and off press.
    alarm_trigger_in = 1'b0;
    cyc("rearm_low2", ex(0,0,0,2'd0));
    alarm_trigger_in = 1'b1;
    cyc("ring4", ex(0,1,0,2'd0));
    snooze_btn = 1'b1;
    cyc("snooze_press4", ex(1,0,0,2'd1));
    tick("snooze4", ex(0,0,1,2'd1));
    tick("snooze4_t1", ex(0,0,1,2'd1));
    alarm_enable_in = 1'b0; clk_1hz_en = 1'b1; off_btn = 1'b1;
    cyc("en_drop_snooze", ex(0,0,0,2'd0));
    alarm_enable_in = 1'b1;
    cyc("idle_no_edge", ex(0,0,0,2'd0));
    // Reset while CLEARING.
    alarm_trigger_in = 1'b0;
    cyc("rearm_low3", ex(0,0,0,2'd0));
    alarm_trigger_in = 1'b1;
    cyc("ring5", ex(0,1,0,2'd0));
    off_btn = 1'b1;
    cyc("clear5", ex(1,0,0,2'd0));
    rst = 1'b1;
    cyc("rst_mid_clearing", ex(0,0,0,2'd0));
    rst = 1'b0; alarm_trigger_in = 1'b0;
    cyc("after_rst", ex(0,0,0,2'd0));
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
